// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO between the uart receiver and the bus RX registers.
// Pushes that arrive while full are dropped and latch the sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid_p,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overrun_q, overrun_d, push_ok, pop_ok;
  assign empty   = count_q == '0;
  assign full    = count_q == CW'(DEPTH);
  assign count   = count_q;
  assign overrun = overrun_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  // A push while full is legal when the head is popped in the same cycle.
  assign push_ok = rx_valid_p & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;
  always_comb begin
    wr_ptr_d  = flush ? '0 : push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = flush ? '0 : pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = flush ? '0 : (push_ok & ~pop_ok) ? count_q + CW'(1) :
                (pop_ok & ~push_ok) ? count_q - CW'(1) : count_q;
    overrun_d = flush ? 1'b0 : (rx_valid_p & full & ~rd_en) ? 1'b1 :
                clr_overrun ? 1'b0 : overrun_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= rx_data;
  end
endmodule
